// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequences the UART receiver (divisor, enable, reset) and buffers received bytes in a FIFO with overrun/irq
module uart_rx_ctrl #(
  parameter int          FIFO_DEPTH  = 4,
  parameter int          PTR_W       = 2,
  parameter logic [31:0] DEFAULT_DIV = 32'd5208,
  parameter logic [31:0] MIN_DIV     = 32'd16,
  parameter int          IRQ_LEVEL   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_we,
  input  logic [31:0]      cfg_div,
  output logic [31:0]      clk_count_bit,
  output logic             rx_rst,
  output logic             rx_en,
  input  logic [7:0]       rx_data,
  input  logic             rx_end,
  input  logic             rd_req,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic [PTR_W:0]   count,
  output logic             overrun,
  input  logic             ovr_clr,
  output logic             irq
);
  typedef enum logic [1:0] {FLUSH, IDLE, LISTEN, HOLD} state_t;
  localparam logic [PTR_W:0] DEPTH = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] LEVEL = (PTR_W+1)'(IRQ_LEVEL);
  state_t           state_q, state_d;
  logic             flush_cnt_q, flush_cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             overrun_q;
  logic [31:0]      div_q;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic             full, pop, rx_ok, push, ovr_set;
  assign full    = count_q == DEPTH;
  assign pop     = rd_req & (count_q != '0);
  assign rx_ok   = rx_end & (state_q != FLUSH);
  // a simultaneous pop frees the slot before the push claims it
  assign push    = rx_ok & (~full | pop);
  assign ovr_set = rx_ok & full & ~pop;
  assign count_d = (push & ~pop) ? count_q + 1'b1 : (pop & ~push) ? count_q - 1'b1 : count_q;
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = 1'b0;
    unique case (state_q)
      FLUSH: begin
        flush_cnt_d = ~flush_cnt_q;
        if (flush_cnt_q) state_d = enable ? LISTEN : IDLE;
      end
      IDLE:   state_d = enable ? LISTEN : IDLE;
      LISTEN: state_d = !enable ? IDLE : (count_d == DEPTH) ? HOLD : LISTEN;
      HOLD:   state_d = !enable ? IDLE : (count_d != DEPTH) ? LISTEN : HOLD;
      default: state_d = FLUSH;
    endcase
    if (cfg_we) begin
      state_d     = FLUSH;
      flush_cnt_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FLUSH;
      flush_cnt_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      div_q       <= DEFAULT_DIV;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      count_q     <= count_d;
      overrun_q   <= ovr_set | (overrun_q & ~ovr_clr);
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (cfg_we) div_q <= (cfg_div < MIN_DIV) ? MIN_DIV : cfg_div;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end
  assign clk_count_bit = div_q;
  assign rx_rst        = state_q == FLUSH;
  assign rx_en         = state_q == LISTEN;
  assign rd_data       = mem_q[rd_ptr_q];
  assign rd_valid      = count_q != '0;
  assign count         = count_q;
  assign overrun       = overrun_q;
  assign irq           = (count_q >= LEVEL) | overrun_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed bench with a byte scoreboard for uart_rx_ctrl
module tb_uart_rx_ctrl;
  logic        clk = 1'b0, reset = 1'b0, enable = 1'b1, cfg_we = 1'b0;
  logic [31:0] cfg_div = '0, clk_count_bit;
  logic        rx_rst, rx_en, rx_end = 1'b0, rd_req = 1'b0, rd_valid, overrun, ovr_clr = 1'b0, irq;
  logic [7:0]  rx_data = '0, rd_data;
  logic [2:0]  count;
  int          tests = 0, fails = 0;
  logic [7:0]  sb[$];
  logic        ovr_m = 1'b0, in_flush = 1'b0;

  uart_rx_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_we(cfg_we), .cfg_div(cfg_div),
    .clk_count_bit(clk_count_bit), .rx_rst(rx_rst), .rx_en(rx_en), .rx_data(rx_data),
    .rx_end(rx_end), .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
    .count(count), .overrun(overrun), .ovr_clr(ovr_clr), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic e, input logic [7:0] d, input logic r, input logic c);
    if (r && sb.size() > 0) begin
      chk("pop_head", rd_data, sb[0]);
      void'(sb.pop_front());
    end
    if (c) ovr_m = 1'b0;
    if (e && !in_flush) begin
      if (sb.size() < 4) sb.push_back(d);
      else ovr_m = 1'b1;
    end
    rx_end = e; rx_data = d; rd_req = r; ovr_clr = c;
    step();
    rx_end = 1'b0; rd_req = 1'b0; ovr_clr = 1'b0;
    chk("count", count, sb.size());
    chk("rd_valid", rd_valid, sb.size() > 0);
    chk("overrun", overrun, ovr_m);
    chk("irq", irq, (sb.size() >= 1) || ovr_m);
    if (sb.size() > 0) chk("head", rd_data, sb[0]);
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_rx_rst", rx_rst, 1);
    chk("rst_rx_en", rx_en, 0);
    chk("rst_div", clk_count_bit, 32'd5208);
    chk("rst_valid", rd_valid, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_irq", irq, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    step();
    chk("flush1_rx_rst", rx_rst, 1);
    chk("flush1_rx_en", rx_en, 0);
    step();
    chk("listen_rx_rst", rx_rst, 0);
    chk("listen_rx_en", rx_en, 1);
    // single byte round trip
    cyc(1, 8'hA5, 0, 0);
    chk("a5_data", rd_data, 8'hA5);
    cyc(0, 0, 1, 0);
    // fill, hold, overrun, drain
    for (int i = 1; i <= 4; i++) cyc(1, 8'(i), 0, 0);
    chk("hold_rx_en", rx_en, 0);
    cyc(1, 8'h05, 0, 0);
    cyc(0, 0, 1, 0);
    chk("relisten_rx_en", rx_en, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    // push and pop on a full FIFO
    for (int i = 1; i <= 4; i++) cyc(1, 8'(i * 8'h11), 0, 0);
    cyc(1, 8'h55, 1, 0);
    // overrun set wins over clear
    cyc(1, 8'h66, 0, 1);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
    // divisor writes and flush restart
    cyc(1, 8'hAA, 0, 0);
    cyc(1, 8'hBB, 0, 0);
    cfg_we = 1'b1; cfg_div = 32'd3;
    step();
    cfg_we = 1'b0;
    chk("clamp_div", clk_count_bit, 32'd16);
    chk("cfg_rx_rst0", rx_rst, 1);
    chk("cfg_count", count, 2);
    step();
    chk("cfg_rx_rst1", rx_rst, 1);
    cfg_we = 1'b1; cfg_div = 32'd100;
    step();
    cfg_we = 1'b0;
    chk("pass_div", clk_count_bit, 32'd100);
    in_flush = 1'b1;
    cyc(1, 8'h77, 0, 0);
    in_flush = 1'b0;
    chk("restart_rx_rst", rx_rst, 1);
    step();
    chk("post_flush_rx_rst", rx_rst, 0);
    chk("post_flush_rx_en", rx_en, 1);
    // enable drop goes idle, bytes still accepted
    enable = 1'b0;
    step();
    chk("idle_rx_en", rx_en, 0);
    chk("idle_rx_rst", rx_rst, 0);
    cyc(1, 8'h88, 0, 0);
    enable = 1'b1;
    step();
    chk("reenable_rx_en", rx_en, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    // asynchronous reset mid-fill
    cyc(1, 8'hC1, 0, 0);
    cyc(1, 8'hC2, 0, 0);
    rx_end = 1'b1; rx_data = 8'hC3;
    #2 reset = 1'b1;
    #1;
    rx_end = 1'b0;
    sb.delete();
    chk("arst_count", count, 0);
    chk("arst_rx_en", rx_en, 0);
    chk("arst_ovr", overrun, 0);
    chk("arst_rx_rst", rx_rst, 1);
    chk("arst_valid", rd_valid, 0);
    chk("arst_div", clk_count_bit, 32'd5208);
    step();
    reset = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
